// File: rtl/dadda_mul_pipe.sv
// dadda_mul_pipe: three-stage pipelined Dadda-tree multiplier with per-operation
// signed (Baugh-Wooley) or unsigned mode and valid/ready handshakes on both sides.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - operand pair offered
//   in_ready   - pair accepted this cycle when high (combinational, from out side only)
//   in_a       - multiplicand, WIDTH bits
//   in_b       - multiplier, WIDTH bits
//   in_signed  - 1: two's-complement operands, 0: unsigned
//   out_valid  - product available
//   out_ready  - consumer takes the product this cycle when high
//   out_p      - product, 2*WIDTH bits
module dadda_mul_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int          NSTAGE = 8;  // heights 2..28 cover operand widths up to 32

  // Dadda target height for reduction step s: 2,3,4,6,9,13,19,28
  function automatic int dadda_height(input int s);
    int d;
    d = 2;
    for (int k = 0; k < s; k++) begin
      d = (d * 3) / 2;
    end
    return d;
  endfunction

  logic en;

  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             s1;
  logic             v1;

  logic [PW-1:0]    row0;
  logic [PW-1:0]    row1;
  logic             v2;

  // Per-column bit heaps used while reducing the partial-product matrix
  logic [WIDTH-1:0] col_cur [PW];
  logic [WIDTH-1:0] col_nxt [PW];
  int               cnt_cur [PW];
  int               cnt_nxt [PW];
  logic [PW-1:0]    row0_c;
  logic [PW-1:0]    row1_c;

  // The whole pipe advances together unless a finished result is waiting
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1 <= '0;
      b1 <= '0;
      s1 <= 1'b0;
      v1 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1 <= in_a;
        b1 <= in_b;
        s1 <= in_signed;
      end
    end
  end

  // Stage 2 logic: partial products and Dadda reduction to two rows
  always_comb begin
    int   d;
    int   idx;
    int   h;
    int   tot;
    logic pp;
    logic x;
    logic y;
    logic z;

    d   = 0;
    idx = 0;
    h   = 0;
    tot = 0;
    pp  = 1'b0;
    x   = 1'b0;
    y   = 1'b0;
    z   = 1'b0;
    for (int i = 0; i < int'(PW); i++) begin
      col_cur[i] = '0;
      col_nxt[i] = '0;
      cnt_cur[i] = 0;
      cnt_nxt[i] = 0;
    end
    row0_c = '0;
    row1_c = '0;

    // Baugh-Wooley: cross terms with exactly one sign bit are inverted
    for (int i = 0; i < int'(WIDTH); i++) begin
      for (int j = 0; j < int'(WIDTH); j++) begin
        pp = a1[j] & b1[i];
        if (s1 && ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1))) begin
          pp = ~pp;
        end
        col_cur[i+j][cnt_cur[i+j]] = pp;
        cnt_cur[i+j] = cnt_cur[i+j] + 1;
      end
    end
    if (s1) begin
      col_cur[WIDTH][cnt_cur[WIDTH]] = 1'b1;
      cnt_cur[WIDTH] = cnt_cur[WIDTH] + 1;
      col_cur[PW-1][cnt_cur[PW-1]] = 1'b1;
      cnt_cur[PW-1] = cnt_cur[PW-1] + 1;
    end

    // Steps whose target is above the current height leave the heap untouched
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      d = dadda_height(s);
      for (int i = 0; i < int'(PW); i++) begin
        col_nxt[i] = '0;
        cnt_nxt[i] = 0;
      end
      for (int i = 0; i < int'(PW); i++) begin
        idx = 0;
        h   = cnt_cur[i];
        for (int k = 0; k < int'(WIDTH); k++) begin
          // carries from the column below are already counted in cnt_nxt
          tot = (h - idx) + cnt_nxt[i];
          if (tot > d) begin
            x = col_cur[i][idx];
            y = col_cur[i][idx+1];
            if (tot == d + 1) begin
              z   = 1'b0;
              idx = idx + 2;
            end else begin
              z   = col_cur[i][idx+2];
              idx = idx + 3;
            end
            col_nxt[i][cnt_nxt[i]] = x ^ y ^ z;
            cnt_nxt[i] = cnt_nxt[i] + 1;
            // carry out of the top column is outside the 2*WIDTH result
            if (i + 1 < int'(PW)) begin
              col_nxt[i+1][cnt_nxt[i+1]] = (x & y) | (x & z) | (y & z);
              cnt_nxt[i+1] = cnt_nxt[i+1] + 1;
            end
          end
        end
        for (int k = 0; k < int'(WIDTH); k++) begin
          if (k >= idx && k < h) begin
            col_nxt[i][cnt_nxt[i]] = col_cur[i][k];
            cnt_nxt[i] = cnt_nxt[i] + 1;
          end
        end
      end
      col_cur = col_nxt;
      cnt_cur = cnt_nxt;
    end

    // unused heap slots are zero, so rows can be read out directly
    for (int i = 0; i < int'(PW); i++) begin
      row0_c[i] = col_cur[i][0];
      row1_c[i] = col_cur[i][1];
    end
  end

  // Stage 2 registers: the two reduced rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row0 <= '0;
      row1 <= '0;
      v2   <= 1'b0;
    end else if (en) begin
      row0 <= row0_c;
      row1 <= row1_c;
      v2   <= v1;
    end
  end

  // Stage 3: final carry-propagate add, truncated to 2*WIDTH bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p     <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_p     <= row0 + row1;
      out_valid <= v2;
    end
  end

endmodule

// File: tb/tb_dadda_mul_pipe.sv
// tb_dadda_mul_pipe: directed corner tables on an 8-bit instance plus randomized
// handshake sweeps at widths 4, 8, 13 and 32 against an arithmetic reference.
module tb_dadda_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic rst8;
  logic rst_r;

  logic        iv8;
  logic        ir8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        s8;
  logic        ov8;
  logic        or8;
  logic [15:0] p8;

  dadda_mul_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_signed(s8), .out_valid(ov8), .out_ready(or8), .out_p(p8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands as integers of width w, multiply, keep 2*w bits
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input int w);
    logic [63:0] mask;
    logic [63:0] p;
    mask = (64'd1 << w) - 64'd1;
    a = a & mask;
    b = b & mask;
    if (s && a[w-1]) a = a | ~mask;
    if (s && b[w-1]) b = b | ~mask;
    p = a * b;
    if (2 * w < 64) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic drive8(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic ordy);
    @(negedge clk);
    iv8 = iv;
    a8  = a;
    b8  = b;
    s8  = s;
    or8 = ordy;
    #1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  vec_t tv[12];
  vec_t bp[5];
  vec_t rv[3];

  // Randomized sweeps, one instance per width
  for (genvar g = 0; g < 4; g++) begin : rnd
    localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 13 : 32;
    logic           iv;
    logic           ir;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic           ov;
    logic           ordy;
    logic [2*W-1:0] p;
    logic           done;
    logic [63:0]    q[$];

    dadda_mul_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b),
      .in_signed(s), .out_valid(ov), .out_ready(ordy), .out_p(p)
    );

    initial begin
      done = 1'b0;
      iv   = 1'b0;
      a    = '0;
      b    = '0;
      s    = 1'b0;
      ordy = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 100 && rst_r; k++) @(negedge clk);
      for (int c = 0; c < 10000 + 10; c++) begin
        @(negedge clk);
        if (c < 10000) begin
          iv   = ($urandom_range(0, 3) != 0);
          ordy = ($urandom_range(0, 3) != 0);
        end else begin
          iv   = 1'b0;
          ordy = 1'b1;
        end
        a = W'($urandom);
        b = W'($urandom);
        s = 1'($urandom_range(0, 1));
        #1;
        if (ov && ordy) begin
          if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL rnd_w%0d_extra: unexpected product %h", W, p);
          end else begin
            check($sformatf("rnd_w%0d", W), 64'(p), q.pop_front());
          end
        end
        if (iv && ir) q.push_back(ref_mul(64'(a), 64'(b), s, W));
      end
      check($sformatf("rnd_w%0d_drained", W), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    tv[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tv[1]  = '{8'h00, 8'hAB, 1'b0, 16'h0000};
    tv[2]  = '{8'h80, 8'h02, 1'b0, 16'h0100};
    tv[3]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tv[4]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tv[5]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tv[6]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tv[7]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tv[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tv[9]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tv[10] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    tv[11] = '{8'h85, 8'h03, 1'b1, 16'hFE8F};

    bp[0] = '{8'h03, 8'h05, 1'b0, 16'h000F};
    bp[1] = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
    bp[2] = '{8'h10, 8'h10, 1'b0, 16'h0100};
    bp[3] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    bp[4] = '{8'hC8, 8'h64, 1'b0, 16'h4E20};

    rv[0] = '{8'h21, 8'h03, 1'b0, 16'h0063};
    rv[1] = '{8'h90, 8'h90, 1'b1, 16'h3100};
    rv[2] = '{8'h0F, 8'h0F, 1'b0, 16'h00E1};

    rst8  = 1'b1;
    rst_r = 1'b1;
    iv8   = 1'b0;
    a8    = '0;
    b8    = '0;
    s8    = 1'b0;
    or8   = 1'b1;
    #23;
    rst8  = 1'b0;
    rst_r = 1'b0;

    // reset state
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("reset_out_valid", 64'(ov8), 64'd0);
    check("reset_out_p", 64'(p8), 64'd0);
    check("reset_in_ready", 64'(ir8), 64'd1);

    // back-to-back corners: each result exactly 3 cycles after its acceptance
    for (int c = 0; c < 12 + 4; c++) begin
      if (c < 12) drive8(1'b1, tv[c].a, tv[c].b, tv[c].s, 1'b1);
      else        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("corner_in_ready", 64'(ir8), 64'd1);
      if (c >= 3 && c - 3 < 12) begin
        check("corner_valid", 64'(ov8), 64'd1);
        check($sformatf("corner_%0d", c - 3), 64'(p8), 64'(tv[c-3].p));
      end else begin
        check("corner_idle", 64'(ov8), 64'd0);
      end
    end

    // backpressure: stall 4 cycles once the first product shows up
    begin
      int idx;
      int got;
      idx = 0;
      got = 0;
      for (int c = 0; c < 20; c++) begin
        if (idx < 5) drive8(1'b1, bp[idx].a, bp[idx].b, bp[idx].s, !(c >= 3 && c <= 6));
        else         drive8(1'b0, 8'h00, 8'h00, 1'b0, !(c >= 3 && c <= 6));
        if (c >= 3 && c <= 6) begin
          check("stall_in_ready", 64'(ir8), 64'd0);
          check("stall_valid", 64'(ov8), 64'd1);
          check("stall_hold", 64'(p8), 64'h000F);
        end
        if (ov8 && or8) begin
          if (got < 5) check($sformatf("bp_%0d", got), 64'(p8), 64'(bp[got].p));
          got++;
        end
        if (iv8 && ir8) idx++;
      end
      check("bp_count", 64'(got), 64'd5);
    end

    // reset mid-flight
    drive8(1'b1, rv[0].a, rv[0].b, rv[0].s, 1'b1);
    drive8(1'b1, rv[1].a, rv[1].b, rv[1].s, 1'b1);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("pre_reset_valid", 64'(ov8), 64'd1);
    check("pre_reset_p", 64'(p8), 64'(rv[0].p));
    #1;
    rst8 = 1'b1;
    #1;
    check("async_reset_valid", 64'(ov8), 64'd0);
    check("async_reset_p", 64'(p8), 64'd0);
    check("async_reset_ready", 64'(ir8), 64'd1);
    @(negedge clk);
    #3;
    rst8 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("post_reset_no_stale", 64'(ov8), 64'd0);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive8(1'b1, rv[2].a, rv[2].b, rv[2].s, 1'b1);
      else        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (c == 3) begin
        check("post_reset_valid", 64'(ov8), 64'd1);
        check("post_reset_p", 64'(p8), 64'(rv[2].p));
      end else begin
        check("post_reset_idle", 64'(ov8), 64'd0);
      end
    end

    // wait for the random sweeps, bounded
    for (int k = 0; k < 30000; k++) begin
      if (rnd[0].done && rnd[1].done && rnd[2].done && rnd[3].done) break;
      @(posedge clk);
    end
    check("random_sweeps_done",
          64'({rnd[0].done, rnd[1].done, rnd[2].done, rnd[3].done}), 64'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
